// File: rtl/sn_tc_pkg.sv
// Shared types for the SN <-> TC work-request path.
package sn_tc_pkg;

  localparam int SN_ADDR_WIDTH  = 64;
  localparam int SN_WL_LEN_BITS = 32;

  typedef struct packed {
    logic [SN_ADDR_WIDTH-1:0]  addr;
    logic [SN_WL_LEN_BITS-1:0] len;
  } sn_req_t;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int clog2_cnt(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sn_req_fifo.sv
// Synchronous request FIFO with a registered head entry that holds its
// last value while the FIFO is empty.
module sn_req_fifo
  import sn_tc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  sn_req_t                     push_data,
  output logic                        full,
  output logic                        empty,
  output logic [clog2_cnt(DEPTH)-1:0] count,
  output sn_req_t                     head
);

  localparam int PW = clog2_cnt(DEPTH);
  localparam int AW = PW - 1;

  sn_req_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_nxt;
  logic [PW-1:0]   rd_nxt;

  always_comb begin
    wr_nxt = wr_ptr + PW'(push);
    rd_nxt = rd_ptr + PW'(pop);
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // The new head comes from the write port when it is the entry being pushed now.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (wr_nxt != rd_nxt) begin
        head <= (rd_nxt == wr_ptr) ? push_data : mem[rd_nxt[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/sn_req_dispatcher.sv
// Presents queued work-list requests to the thread controller, limits the
// number in flight and flags handshake violations.
module sn_req_dispatcher
  import sn_tc_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int WL_LEN_BITS     = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ADDR_WIDTH-1:0]                 in_addr,
  input  logic [WL_LEN_BITS-1:0]                in_len,
  output logic                                  next_op,
  output logic [ADDR_WIDTH-1:0]                 next_addr,
  output logic [WL_LEN_BITS-1:0]                next_len,
  input  logic                                  clr_next,
  input  logic                                  req_done,
  output logic [$clog2(DEPTH):0]                queue_count,
  output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
  output logic                                  idle,
  output logic                                  proto_err
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] ONE     = OW'(1);

  sn_req_t in_req;
  sn_req_t head;
  logic    full;
  logic    empty;
  logic    push;
  logic    pop;
  logic    done_ok;

  assign in_req.addr = SN_ADDR_WIDTH'(in_addr);
  assign in_req.len  = SN_WL_LEN_BITS'(in_len);

  // Zero-length requests are acknowledged but never reach the FIFO.
  assign in_ready = !full;
  assign push     = in_valid && in_ready && (in_len != '0);
  assign next_op  = !empty && (outstanding < MAX_OUT);
  assign pop      = clr_next && next_op;
  assign done_ok  = req_done && (outstanding != '0);

  assign next_addr = ADDR_WIDTH'(head.addr);
  assign next_len  = WL_LEN_BITS'(head.len);
  assign idle      = (queue_count == '0) && (outstanding == '0);

  sn_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(in_req),
    .full     (full),
    .empty    (empty),
    .count    (queue_count),
    .head     (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (pop && !done_ok) begin
        outstanding <= outstanding + ONE;
      end else if (!pop && done_ok) begin
        outstanding <= outstanding - ONE;
      end
      if ((clr_next && !next_op) || (req_done && (outstanding == '0))) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
